muldiv_issue_ctrl: RTL and testbench

EX-stage requester for the multi-cycle M-extension multiply/divide unit. It decodes M-extension ALU control codes and launches the operation with a one-cycle start pulse. It stalls the pipeline until the unit's done pulse arrives, then presents the result for one cycle.
It also handles flush of an in-flight operation, a watchdog timeout, and a one-entry result reuse cache for repeated identical operations.

---
 rtl/muldiv_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage requester for the multi-cycle M-extension multiply/divide unit: launch, stall,
// flush draining, watchdog timeout and a one-entry result reuse cache.
module muldiv_issue_ctrl #(
  parameter int XLEN     = 32,
  parameter int TIMEOUT  = 80,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_alu_ctrl,
  input  logic [XLEN-1:0] ex_rs1_val,
  input  logic [XLEN-1:0] ex_rs2_val,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            unit_start,
  output logic [4:0]      unit_op,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_result,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            busy,
  output logic            timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESULT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [4:0]      op_q, rd_q, c_op;
  logic [XLEN-1:0] a_q, b_q, res_q, c_a, c_b, c_res;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            cache_valid, timeout_q;

  logic is_m, hit, cnt_hit;
  logic do_latch, do_hit, do_done, do_to, do_clr, do_inc;

  assign is_m    = ex_valid & ex_alu_ctrl[4] & ~flush;
  assign hit     = (CACHE_EN != 0) && cache_valid && (ex_alu_ctrl == c_op) &&
                   (ex_rs1_val == c_a) && (ex_rs2_val == c_b);
  assign cnt_inc = cnt + CW'(1);
  assign cnt_hit = (cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    do_latch  = 1'b0;
    do_hit    = 1'b0;
    do_done   = 1'b0;
    do_to     = 1'b0;
    do_clr    = 1'b0;
    do_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (is_m) begin
          stall = 1'b1;
          if (hit) begin
            do_hit    = 1'b1;
            state_nxt = RESULT;
          end else begin
            do_latch  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        stall     = 1'b1;
        do_clr    = 1'b1;
        state_nxt = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (unit_done) begin
          do_done   = 1'b1;
          state_nxt = flush ? IDLE : RESULT;
        end else if (cnt_hit) begin
          do_to     = 1'b1;
          state_nxt = flush ? IDLE : RESULT;
        end else begin
          do_inc    = 1'b1;
          state_nxt = flush ? DRAIN : WAIT;
        end
      end
      RESULT: begin
        state_nxt = IDLE;
      end
      DRAIN: begin
        // The unit cannot abort, so only a new M-op has to wait for it to go quiet.
        stall = is_m;
        if (unit_done) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_hit) begin
          do_to     = 1'b1;
          state_nxt = IDLE;
        end else begin
          do_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      cnt         <= '0;
      cache_valid <= 1'b0;
      c_op        <= '0;
      c_a         <= '0;
      c_b         <= '0;
      c_res       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (do_latch) begin
        op_q <= ex_alu_ctrl;
        a_q  <= ex_rs1_val;
        b_q  <= ex_rs2_val;
        rd_q <= ex_rd;
      end
      if (do_hit) begin
        rd_q  <= ex_rd;
        res_q <= c_res;
      end
      if (do_clr)      cnt <= '0;
      else if (do_inc) cnt <= cnt_inc;
      // Even a drained result is remembered; the operands describe it exactly.
      if (do_done) begin
        res_q       <= unit_result;
        cache_valid <= 1'b1;
        c_op        <= op_q;
        c_a         <= a_q;
        c_b         <= b_q;
        c_res       <= unit_result;
      end
      if (do_to) begin
        res_q       <= '0;
        timeout_q   <= 1'b1;
        cache_valid <= 1'b0;
      end
    end
  end

  assign unit_start  = (state == ISSUE);
  assign unit_op     = op_q;
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign busy        = (state == ISSUE) || (state == WAIT) || (state == DRAIN);
  assign res_valid   = (state == RESULT);
  assign res_data    = res_valid ? res_q : '0;
  assign res_rd      = res_valid ? rd_q : '0;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl: a cycle-by-cycle vector table plus hand-written
// sequences for long latency, reuse, flush/drain, watchdog and reset.
module tb_muldiv_issue_ctrl;

  localparam logic [4:0] ADD    = 5'b00000;
  localparam logic [4:0] MUL    = 5'b10000;
  localparam logic [4:0] MULH   = 5'b10001;
  localparam logic [4:0] MULHSU = 5'b10010;
  localparam logic [4:0] DIV    = 5'b10100;
  localparam logic [4:0] DIVU   = 5'b10101;
  localparam logic [4:0] REM    = 5'b10110;

  logic        clk, rst, ex_valid, flush, unit_done;
  logic [4:0]  ex_alu_ctrl, ex_rd, unit_op, res_rd;
  logic [31:0] ex_rs1_val, ex_rs2_val, unit_a, unit_b, unit_result, res_data;
  logic        unit_start, stall, res_valid, busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_issue_ctrl #(.XLEN(32), .TIMEOUT(80), .CACHE_EN(1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .flush(flush),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result), .stall(stall),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        fl;
    logic        done;
    logic [31:0] ures;
    logic        e_stall;
    logic        e_start;
    logic        e_rv;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_busy;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic v, logic [4:0] ctrl, logic [31:0] a, logic [31:0] b,
                              logic [4:0] rd, logic fl, logic done, logic [31:0] ures,
                              logic e_stall, logic e_start, logic e_rv, logic [31:0] e_data,
                              logic [4:0] e_rd, logic e_busy);
    vec_t r;
    r.v = v; r.ctrl = ctrl; r.a = a; r.b = b; r.rd = rd; r.fl = fl; r.done = done;
    r.ures = ures; r.e_stall = e_stall; r.e_start = e_start; r.e_rv = e_rv;
    r.e_data = e_data; r.e_rd = e_rd; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ex(input logic v, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    ex_valid = v; ex_alu_ctrl = ctrl; ex_rs1_val = a; ex_rs2_val = b; ex_rd = rd;
  endtask

  task automatic set_unit(input logic done, input logic [31:0] res);
    unit_done = done; unit_result = res;
  endtask

  task automatic applyStimulus(input vec_t v);
    set_ex(v.v, v.ctrl, v.a, v.b, v.rd);
    flush = v.fl;
    set_unit(v.done, v.ures);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    //          v    ctrl  a      b      rd    fl   done ures       stall st   rv   data        rd    busy
    tbl[0]  = mk(1'b0, ADD,  32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[1]  = mk(1'b1, ADD,  32'd1, 32'd2, 5'd5, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[2]  = mk(1'b1, MUL,  32'd6, 32'd9, 5'd3, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[3]  = mk(1'b1, MUL,  32'd6, 32'd9, 5'd3, 1'b0, 1'b0, 32'd0,    1'b1, 1'b1, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[4]  = mk(1'b1, MUL,  32'd6, 32'd9, 5'd3, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[5]  = mk(1'b1, MUL,  32'd6, 32'd9, 5'd3, 1'b0, 1'b1, 32'd54,   1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[6]  = mk(1'b1, MUL,  32'd6, 32'd9, 5'd3, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b1, 32'd54,   5'd3, 1'b0);
    tbl[7]  = mk(1'b1, ADD,  32'd4, 32'd4, 5'd6, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[8]  = mk(1'b0, ADD,  32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd99,   1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[9]  = mk(1'b1, MUL,  32'd6, 32'd9, 5'd7, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[10] = mk(1'b1, MUL,  32'd6, 32'd9, 5'd7, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b1, 32'd54,   5'd7, 1'b0);
    tbl[11] = mk(1'b0, ADD,  32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[12] = mk(1'b1, MULH, 32'd6, 32'd9, 5'd8, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[13] = mk(1'b1, MULH, 32'd6, 32'd9, 5'd8, 1'b1, 1'b0, 32'd0,    1'b1, 1'b1, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[14] = mk(1'b1, ADD,  32'd1, 32'd1, 5'd9, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[15] = mk(1'b1, MUL,  32'd6, 32'd9, 5'd2, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[16] = mk(1'b1, MUL,  32'd6, 32'd9, 5'd2, 1'b0, 1'b1, 32'd1234, 1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b1);
    tbl[17] = mk(1'b1, MULH, 32'd6, 32'd9, 5'd4, 1'b0, 1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);
    tbl[18] = mk(1'b1, MULH, 32'd6, 32'd9, 5'd4, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b1, 32'd1234, 5'd4, 1'b0);
    tbl[19] = mk(1'b0, ADD,  32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 32'd0,    5'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkBit($sformatf("tbl[%0d] stall", i), stall, tbl[i].e_stall);
      checkBit($sformatf("tbl[%0d] unit_start", i), unit_start, tbl[i].e_start);
      checkBit($sformatf("tbl[%0d] res_valid", i), res_valid, tbl[i].e_rv);
      checkOutput($sformatf("tbl[%0d] res_data", i), res_data, tbl[i].e_data);
      checkOutput($sformatf("tbl[%0d] res_rd", i), {27'd0, res_rd}, {27'd0, tbl[i].e_rd});
      checkBit($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
      checkBit($sformatf("tbl[%0d] timeout_err", i), timeout_err, 1'b0);
      next_cycle();
    end

    // MUL 7 * -3, done 33 cycles after the start pulse.
    set_ex(1'b1, MUL, 32'd7, 32'hFFFF_FFFD, 5'd11);
    for (int n = 0; n <= 35; n++) begin
      set_unit(n == 34, (n == 34) ? 32'hFFFF_FFEB : 32'd0);
      @(negedge clk);
      checkBit($sformatf("A stall n=%0d", n), stall, n <= 34);
      checkBit($sformatf("A start n=%0d", n), unit_start, n == 1);
      checkBit($sformatf("A res_valid n=%0d", n), res_valid, n == 35);
      if (n == 2) begin
        checkOutput("A unit_a", unit_a, 32'd7);
        checkOutput("A unit_b", unit_b, 32'hFFFF_FFFD);
        checkOutput("A unit_op", {27'd0, unit_op}, {27'd0, MUL});
      end
      if (n == 35) begin
        checkOutput("A res_data", res_data, 32'hFFFF_FFEB);
        checkOutput("A res_rd", {27'd0, res_rd}, 32'd11);
      end
      next_cycle();
    end
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);
    next_cycle();

    // DIVU 100/7 twice back to back; the second comes from the cache.
    for (int n = 0; n <= 6; n++) begin
      set_ex(1'b1, DIVU, 32'd100, 32'd7, (n >= 5) ? 5'd13 : 5'd12);
      set_unit(n == 3, (n == 3) ? 32'd14 : 32'd0);
      @(negedge clk);
      checkBit($sformatf("B stall n=%0d", n), stall, (n <= 3) || (n == 5));
      checkBit($sformatf("B start n=%0d", n), unit_start, n == 1);
      checkBit($sformatf("B res_valid n=%0d", n), res_valid, (n == 4) || (n == 6));
      if (n == 4 || n == 6) begin
        checkOutput($sformatf("B res_data n=%0d", n), res_data, 32'd14);
        checkOutput($sformatf("B res_rd n=%0d", n), {27'd0, res_rd}, (n == 4) ? 32'd12 : 32'd13);
      end
      next_cycle();
    end
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);
    next_cycle();

    // DIV flushed 5 cycles into WAIT, ADD passes, MUL waits out the drain.
    for (int n = 0; n <= 14; n++) begin
      if (n < 7)       set_ex(1'b1, DIV, 32'd200, 32'd10, 5'd14);
      else if (n == 7) set_ex(1'b1, ADD, 32'd1, 32'd1, 5'd1);
      else             set_ex(1'b1, MUL, 32'd3, 32'd4, 5'd15);
      flush = (n == 6);
      set_unit((n == 10) || (n == 13), (n == 10) ? 32'd20 : 32'd12);
      @(negedge clk);
      checkBit($sformatf("C stall n=%0d", n), stall, (n <= 6) || (n >= 8 && n <= 13));
      checkBit($sformatf("C start n=%0d", n), unit_start, (n == 1) || (n == 12));
      checkBit($sformatf("C res_valid n=%0d", n), res_valid, n == 14);
      checkBit($sformatf("C busy n=%0d", n), busy, (n >= 1 && n <= 10) || n == 12 || n == 13);
      if (n == 12) checkOutput("C unit_a", unit_a, 32'd3);
      if (n == 14) begin
        checkOutput("C res_data", res_data, 32'd12);
        checkOutput("C res_rd", {27'd0, res_rd}, 32'd15);
      end
      next_cycle();
    end
    flush = 1'b0;
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);
    next_cycle();

    // Watchdog: the unit never answers.
    set_ex(1'b1, MULHSU, 32'd5, 32'd5, 5'd16);
    for (int n = 0; n <= 82; n++) begin
      @(negedge clk);
      checkBit($sformatf("D stall n=%0d", n), stall, n <= 81);
      checkBit($sformatf("D res_valid n=%0d", n), res_valid, n == 82);
      checkBit($sformatf("D timeout_err n=%0d", n), timeout_err, n >= 82);
      if (n == 82) begin
        checkOutput("D res_data", res_data, 32'd0);
        checkOutput("D res_rd", {27'd0, res_rd}, 32'd16);
      end
      next_cycle();
    end
    // MUL 3*4 was cached before the timeout; it must now miss.
    for (int n = 0; n <= 3; n++) begin
      set_ex(1'b1, MUL, 32'd3, 32'd4, 5'd17);
      set_unit(n == 2, (n == 2) ? 32'd12 : 32'd0);
      @(negedge clk);
      checkBit($sformatf("D2 start n=%0d", n), unit_start, n == 1);
      checkBit($sformatf("D2 res_valid n=%0d", n), res_valid, n == 3);
      checkBit($sformatf("D2 timeout_err n=%0d", n), timeout_err, 1'b1);
      next_cycle();
    end
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);
    next_cycle();

    // Reset in WAIT, late done ignored, cache cleared.
    for (int n = 0; n <= 10; n++) begin
      if (n <= 2)      set_ex(1'b1, MUL, 32'd8, 32'd8, 5'd18);
      else if (n >= 7) set_ex(1'b1, MUL, 32'd3, 32'd4, 5'd19);
      else             set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
      rst = (n == 3);
      set_unit((n == 5) || (n == 9), (n == 5) ? 32'd77 : 32'd12);
      @(negedge clk);
      if (n == 3) checkBit("E stall before reset edge", stall, 1'b1);
      if (n >= 4 && n <= 6) begin
        checkBit($sformatf("E stall n=%0d", n), stall, 1'b0);
        checkBit($sformatf("E busy n=%0d", n), busy, 1'b0);
        checkBit($sformatf("E res_valid n=%0d", n), res_valid, 1'b0);
        checkBit($sformatf("E start n=%0d", n), unit_start, 1'b0);
        checkBit($sformatf("E timeout_err n=%0d", n), timeout_err, 1'b0);
      end
      if (n >= 7) begin
        checkBit($sformatf("E start n=%0d", n), unit_start, n == 8);
        checkBit($sformatf("E res_valid n=%0d", n), res_valid, n == 10);
      end
      if (n == 10) checkOutput("E res_data", res_data, 32'd12);
      next_cycle();
    end
    rst = 1'b0;
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);
    next_cycle();

    // Flush coincident with done in WAIT: no result, but the cache learns it.
    for (int n = 0; n <= 6; n++) begin
      if (n <= 2)      set_ex(1'b1, REM, 32'd50, 32'd7, 5'd20);
      else if (n >= 5) set_ex(1'b1, REM, 32'd50, 32'd7, 5'd21);
      else             set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
      flush = (n == 3);
      set_unit(n == 3, (n == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
      checkBit($sformatf("F start n=%0d", n), unit_start, n == 1);
      checkBit($sformatf("F res_valid n=%0d", n), res_valid, n == 6);
      checkBit($sformatf("F busy n=%0d", n), busy, (n >= 1 && n <= 3));
      if (n == 4) checkBit("F stall after flush+done", stall, 1'b0);
      if (n == 6) begin
        checkOutput("F res_data", res_data, 32'd1);
        checkOutput("F res_rd", {27'd0, res_rd}, 32'd21);
      end
      next_cycle();
    end
    flush = 1'b0;
    set_ex(1'b0, ADD, 32'd0, 32'd0, 5'd0);
    set_unit(1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
